// File: rtl/cam_masked.sv
// Masked content-addressable memory with per-entry valid bits and invalidate.
// Reads and searches see the pre-edge array state and return registered results.
`timescale 1ns/1ps
module cam_masked #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH_LOG2 = 5
) (
    input  logic                  clk,
    input  logic                  reset_i,
    input  logic                  read_i,
    input  logic [DEPTH_LOG2-1:0] read_index_i,
    input  logic                  write_i,
    input  logic [DEPTH_LOG2-1:0] write_index_i,
    input  logic [DATA_WIDTH-1:0] write_data_i,
    input  logic                  invalidate_i,
    input  logic [DEPTH_LOG2-1:0] invalidate_index_i,
    input  logic                  search_i,
    input  logic [DATA_WIDTH-1:0] search_data_i,
    input  logic [DATA_WIDTH-1:0] search_mask_i,
    output logic                  read_valid_o,
    output logic [DATA_WIDTH-1:0] read_value_o,
    output logic                  search_valid_o,
    output logic [DEPTH_LOG2-1:0] search_index_o,
    output logic                  search_multi_o,
    output logic [DEPTH_LOG2:0]   occupancy_o,
    output logic                  full_o
);

    localparam int N     = 2 ** DEPTH_LOG2;
    localparam int OCC_W = DEPTH_LOG2 + 1;

    logic [DATA_WIDTH-1:0] mem_q [N];
    logic [N-1:0]          valid_q, valid_d;
    logic [OCC_W-1:0]      occ_q, occ_d;
    logic                  full_q, full_d;

    logic                  read_valid_q, read_valid_d;
    logic [DATA_WIDTH-1:0] read_value_q, read_value_d;
    logic                  search_valid_q, search_valid_d;
    logic [DEPTH_LOG2-1:0] search_index_q, search_index_d;
    logic                  search_multi_q, search_multi_d;

    logic [N-1:0]          match;
    logic [OCC_W-1:0]      hit_cnt;
    logic [DEPTH_LOG2-1:0] lowest;

    // Write is applied after invalidate so it wins on a shared index.
    always_comb begin
        valid_d = valid_q;
        if (invalidate_i) valid_d[invalidate_index_i] = 1'b0;
        if (write_i)      valid_d[write_index_i]      = 1'b1;
        occ_d = '0;
        for (int i = 0; i < N; i++) begin
            occ_d = occ_d + OCC_W'(valid_d[i]);
        end
        full_d = (occ_d == OCC_W'(N));
    end

    always_comb begin
        read_valid_d = read_i & valid_q[read_index_i];
        read_value_d = read_valid_d ? mem_q[read_index_i] : '0;
    end

    // Descending scan leaves the lowest matching index in 'lowest'.
    always_comb begin
        match   = '0;
        hit_cnt = '0;
        lowest  = '0;
        for (int i = 0; i < N; i++) begin
            match[i] = valid_q[i] &&
                       (((mem_q[i] ^ search_data_i) & search_mask_i) == '0);
            hit_cnt  = hit_cnt + OCC_W'(match[i]);
        end
        for (int i = N - 1; i >= 0; i--) begin
            if (match[i]) lowest = DEPTH_LOG2'(i);
        end
        search_valid_d = search_i && (hit_cnt != '0);
        search_index_d = search_valid_d ? lowest : '0;
        search_multi_d = search_i && (hit_cnt > OCC_W'(1));
    end

    always_ff @(posedge clk) begin
        if (!reset_i) begin
            valid_q        <= '0;
            occ_q          <= '0;
            full_q         <= 1'b0;
            read_valid_q   <= 1'b0;
            read_value_q   <= '0;
            search_valid_q <= 1'b0;
            search_index_q <= '0;
            search_multi_q <= 1'b0;
        end else begin
            valid_q        <= valid_d;
            occ_q          <= occ_d;
            full_q         <= full_d;
            read_valid_q   <= read_valid_d;
            read_value_q   <= read_value_d;
            search_valid_q <= search_valid_d;
            search_index_q <= search_index_d;
            search_multi_q <= search_multi_d;
        end
    end

    // Data array carries no reset; entries are meaningless until their valid bit is set.
    always_ff @(posedge clk) begin
        if (reset_i && write_i) mem_q[write_index_i] <= write_data_i;
    end

    assign read_valid_o   = read_valid_q;
    assign read_value_o   = read_value_q;
    assign search_valid_o = search_valid_q;
    assign search_index_o = search_index_q;
    assign search_multi_o = search_multi_q;
    assign occupancy_o    = occ_q;
    assign full_o         = full_q;

endmodule

// File: tb/tb_cam_masked.sv
// Scoreboard bench for cam_masked: the driver queues hand-computed results per cycle,
// a monitor pops and compares them one edge later.
`timescale 1ns/1ps
module tb_cam_masked;

    logic        clk;
    logic        reset_i;
    logic        read_i;
    logic [4:0]  read_index_i;
    logic        write_i;
    logic [4:0]  write_index_i;
    logic [31:0] write_data_i;
    logic        invalidate_i;
    logic [4:0]  invalidate_index_i;
    logic        search_i;
    logic [31:0] search_data_i;
    logic [31:0] search_mask_i;
    logic        read_valid_o;
    logic [31:0] read_value_o;
    logic        search_valid_o;
    logic [4:0]  search_index_o;
    logic        search_multi_o;
    logic [5:0]  occupancy_o;
    logic        full_o;

    cam_masked #(.DATA_WIDTH(32), .DEPTH_LOG2(5)) dut (
        .clk                (clk),
        .reset_i            (reset_i),
        .read_i             (read_i),
        .read_index_i       (read_index_i),
        .write_i            (write_i),
        .write_index_i      (write_index_i),
        .write_data_i       (write_data_i),
        .invalidate_i       (invalidate_i),
        .invalidate_index_i (invalidate_index_i),
        .search_i           (search_i),
        .search_data_i      (search_data_i),
        .search_mask_i      (search_mask_i),
        .read_valid_o       (read_valid_o),
        .read_value_o       (read_value_o),
        .search_valid_o     (search_valid_o),
        .search_index_o     (search_index_o),
        .search_multi_o     (search_multi_o),
        .occupancy_o        (occupancy_o),
        .full_o             (full_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        bit          ck_rd;
        logic        rv;
        logic [31:0] rval;
        bit          ck_sr;
        logic        sv;
        logic [4:0]  sidx;
        logic        sm;
        bit          ck_oc;
        logic [5:0]  occ;
        logic        full;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks   = 0;
    int   failures = 0;

    task automatic idle();
        read_i = 0; read_index_i = 0;
        write_i = 0; write_index_i = 0; write_data_i = 0;
        invalidate_i = 0; invalidate_index_i = 0;
        search_i = 0; search_data_i = 0; search_mask_i = 0;
    endtask

    // Queue the expected outcome of the inputs currently driven, then run one edge.
    task automatic step(input string n,
                        input bit crd, input logic erv, input logic [31:0] erval,
                        input bit csr, input logic esv, input logic [4:0] esi, input logic esm,
                        input bit coc, input logic [5:0] eocc, input logic efull);
        exp_t e;
        e.name = n; e.ck_rd = crd; e.rv = erv; e.rval = erval;
        e.ck_sr = csr; e.sv = esv; e.sidx = esi; e.sm = esm;
        e.ck_oc = coc; e.occ = eocc; e.full = efull;
        exp_q.push_back(e);
        @(posedge clk);
        @(negedge clk);
        idle();
    endtask

    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            if (mon_e.ck_rd) begin
                checks++;
                if ({read_valid_o, read_value_o} !== {mon_e.rv, mon_e.rval}) begin
                    failures++;
                    $display("FAIL %s read: got v=%0b val=%h, want v=%0b val=%h",
                             mon_e.name, read_valid_o, read_value_o, mon_e.rv, mon_e.rval);
                end
            end
            if (mon_e.ck_sr) begin
                checks++;
                if ({search_valid_o, search_index_o, search_multi_o} !==
                    {mon_e.sv, mon_e.sidx, mon_e.sm}) begin
                    failures++;
                    $display("FAIL %s search: got v=%0b idx=%0d multi=%0b, want v=%0b idx=%0d multi=%0b",
                             mon_e.name, search_valid_o, search_index_o, search_multi_o,
                             mon_e.sv, mon_e.sidx, mon_e.sm);
                end
            end
            if (mon_e.ck_oc) begin
                checks++;
                if ({occupancy_o, full_o} !== {mon_e.occ, mon_e.full}) begin
                    failures++;
                    $display("FAIL %s occupancy: got occ=%0d full=%0b, want occ=%0d full=%0b",
                             mon_e.name, occupancy_o, full_o, mon_e.occ, mon_e.full);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0] occ_e;
        bit         pre;
        idle();
        reset_i = 0;
        @(negedge clk);
        step("rst0", 1,0,0, 1,0,0,0, 1,0,0);
        step("rst1", 1,0,0, 1,0,0,0, 1,0,0);
        reset_i = 1;

        // Four writes, occupancy counts up
        write_i = 1; write_index_i = 1; write_data_i = 32'h1; step("wr1", 1,0,0, 1,0,0,0, 1,1,0);
        write_i = 1; write_index_i = 3; write_data_i = 32'h3; step("wr3", 0,0,0, 0,0,0,0, 1,2,0);
        write_i = 1; write_index_i = 5; write_data_i = 32'h5; step("wr5", 0,0,0, 0,0,0,0, 1,3,0);
        write_i = 1; write_index_i = 7; write_data_i = 32'h7; step("wr7", 0,0,0, 0,0,0,0, 1,4,0);
        read_i = 1; read_index_i = 3; step("rd3", 1,1,32'h3, 1,0,0,0, 1,4,0);
        read_i = 1; read_index_i = 4; step("rd4", 1,0,0, 0,0,0,0, 0,0,0);

        // Read/search see pre-write state in the same cycle
        read_i = 1; read_index_i = 5;
        write_i = 1; write_index_i = 5; write_data_i = 32'h9;
        search_i = 1; search_data_i = 32'h5; search_mask_i = 32'hFFFF_FFFF;
        step("same_cyc", 1,1,32'h5, 1,1,5,0, 1,4,0);
        search_i = 1; search_data_i = 32'h5; search_mask_i = 32'hFFFF_FFFF;
        step("srch_old", 1,0,0, 1,0,0,0, 0,0,0);
        search_i = 1; search_data_i = 32'h9; search_mask_i = 32'hFFFF_FFFF;
        step("srch_new", 0,0,0, 1,1,5,0, 0,0,0);

        // Masked search with two candidates
        write_i = 1; write_index_i = 2; write_data_i = 32'hAB00; step("wr2", 0,0,0, 0,0,0,0, 1,5,0);
        write_i = 1; write_index_i = 9; write_data_i = 32'hAB11; step("wr9", 0,0,0, 0,0,0,0, 1,6,0);
        search_i = 1; search_data_i = 32'hAB00; search_mask_i = 32'hFF00;
        step("mask_ff00", 0,0,0, 1,1,2,1, 0,0,0);
        search_i = 1; search_data_i = 32'hAB00; search_mask_i = 32'hFFFF;
        step("mask_ffff", 0,0,0, 1,1,2,0, 0,0,0);

        // Invalidate paths
        invalidate_i = 1; invalidate_index_i = 2; step("inv2", 0,0,0, 0,0,0,0, 1,5,0);
        invalidate_i = 1; invalidate_index_i = 2; step("inv2_again", 0,0,0, 0,0,0,0, 1,5,0);
        read_i = 1; read_index_i = 2; step("rd2_inv", 1,0,0, 0,0,0,0, 1,5,0);
        write_i = 1; write_index_i = 2; write_data_i = 32'hCAFE;
        invalidate_i = 1; invalidate_index_i = 2;
        step("wr_inv_same", 0,0,0, 0,0,0,0, 1,6,0);
        read_i = 1; read_index_i = 2; step("rd2_new", 1,1,32'hCAFE, 0,0,0,0, 1,6,0);
        write_i = 1; write_index_i = 10; write_data_i = 32'hA;
        invalidate_i = 1; invalidate_index_i = 1;
        step("wr_inv_diff", 0,0,0, 0,0,0,0, 1,6,0);

        // Fill every entry; valid set beforehand is {2,3,5,7,9,10}
        occ_e = 6;
        for (int i = 0; i < 32; i++) begin
            pre = (i == 2) || (i == 3) || (i == 5) || (i == 7) || (i == 9) || (i == 10);
            if (!pre) occ_e = occ_e + 1;
            write_i = 1; write_index_i = 5'(i); write_data_i = 32'h100 + 32'(i);
            step("fill", 0,0,0, 0,0,0,0, 1, occ_e, (occ_e == 6'd32));
        end
        write_i = 1; write_index_i = 0; write_data_i = 32'h55;
        step("overwrite_full", 0,0,0, 0,0,0,0, 1,32,1);
        invalidate_i = 1; invalidate_index_i = 31;
        step("inv31", 0,0,0, 0,0,0,0, 1,31,0);
        search_i = 1; search_data_i = 32'hDEAD_BEEF; search_mask_i = 32'h0;
        read_i = 1; read_index_i = 0;
        step("mask_zero", 1,1,32'h55, 1,1,0,1, 1,31,0);
        search_i = 1; search_data_i = 32'h111; search_mask_i = 32'hFFFF_FFFF;
        step("srch17", 0,0,0, 1,1,17,0, 0,0,0);
        search_i = 1; search_data_i = 32'h11F; search_mask_i = 32'hFFFF_FFFF;
        step("srch31_gone", 0,0,0, 1,0,0,0, 0,0,0);

        // Reset mid-sequence with requests that must be ignored
        reset_i = 0;
        write_i = 1; write_index_i = 31; write_data_i = 32'h77;
        invalidate_i = 1; invalidate_index_i = 0;
        search_i = 1; search_data_i = 32'h0; search_mask_i = 32'h0;
        read_i = 1; read_index_i = 0;
        step("rst_mid", 1,0,0, 1,0,0,0, 1,0,0);
        reset_i = 1;
        read_i = 1; read_index_i = 0;
        search_i = 1; search_data_i = 32'h0; search_mask_i = 32'h0;
        step("post_rst_rd0", 1,0,0, 1,0,0,0, 1,0,0);
        read_i = 1; read_index_i = 31; step("post_rst_rd31", 1,0,0, 0,0,0,0, 1,0,0);
        write_i = 1; write_index_i = 4; write_data_i = 32'h44; step("post_rst_wr", 0,0,0, 0,0,0,0, 1,1,0);
        read_i = 1; read_index_i = 4; step("post_rst_rd4", 1,1,32'h44, 0,0,0,0, 1,1,0);
        step("idle_pulse", 1,0,0, 1,0,0,0, 1,1,0);

        @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d pending entries, want 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cam_masked.md
Name: cam_masked

Overview:
Parametrised successor to the lab1 content-addressable memory. It adds per-entry valid bits, an explicit invalidate operation, masked (ternary-style) search, lowest-index priority resolution with a multi-hit flag, and occupancy/full status. All read and search results are registered with one-cycle latency. It sits beside the lab1 cam as a drop-in for lookup tables that need entry retirement.

Parameters:
DATA_WIDTH, 32, width of each stored word and of the search key.
DEPTH_LOG2, 5, log2 of entry count; the array holds 2**DEPTH_LOG2 entries.

Ports:
clk  input  1  clock; all state updates on the rising edge.
reset_i  input  1  synchronous, active-low reset.
read_i  input  1  read request.
read_index_i  input  DEPTH_LOG2  entry to read.
write_i  input  1  write request.
write_index_i  input  DEPTH_LOG2  entry to write.
write_data_i  input  DATA_WIDTH  data to store.
invalidate_i  input  1  invalidate request.
invalidate_index_i  input  DEPTH_LOG2  entry to invalidate.
search_i  input  1  search request.
search_data_i  input  DATA_WIDTH  search key.
search_mask_i  input  DATA_WIDTH  per-bit compare enable; 1 = compare, 0 = don't care.
read_valid_o  output  1  read hit on a valid entry.
read_value_o  output  DATA_WIDTH  read data.
search_valid_o  output  1  at least one valid entry matched.
search_index_o  output  DEPTH_LOG2  lowest matching index.
search_multi_o  output  1  two or more entries matched.
occupancy_o  output  DEPTH_LOG2+1  count of valid entries.
full_o  output  1  occupancy equals 2**DEPTH_LOG2.

Behaviour:
- Reset (reset_i==0 at a rising edge):
  - all valid bits cleared; data array contents need not be cleared.
  - every output is 0 after that edge.
  - requests presented in a reset cycle are ignored entirely, including when reset asserts mid-sequence.
- Ordering: all four operations are independent and may be issued in the same cycle. They are sampled on the rising edge.
  - Read and search evaluate the pre-edge array state. A read or search in the same cycle as a write or invalidate does not see that update.
- Read:
  - result is registered and appears the cycle after read_i=1.
  - valid entry: read_valid_o=1, read_value_o=stored data.
  - invalid entry: read_valid_o=0, read_value_o=0.
  - read_i=0: both outputs are 0 the next cycle (pulse semantics, no hold).
- Write: the entry gets write_data_i and its valid bit is set.
  - Overwriting a valid entry is allowed and leaves occupancy unchanged.
- Invalidate: clears the valid bit. Invalidating an already-invalid entry is a no-op.
- Write and invalidate to the same index in the same cycle: the write wins, so the entry ends valid with the new data. Occupancy changes as for the write alone.
- Occupancy:
  - +1 for a write to an invalid entry.
  - −1 for an invalidate of a valid entry (not overridden by a write).
  - Both on different indices in the same cycle: net 0.
  - Never wraps. full_o is registered and consistent with occupancy_o.
- Search:
  - entry i matches when valid[i] is set and ((stored ^ search_data_i) & search_mask_i)==0.
  - An all-zero mask matches every valid entry.
  - Result is registered, one-cycle latency.
  - search_index_o is the lowest matching index; search_multi_o=1 when two or more entries match.
  - On a miss, or when search_i=0: search_valid_o=0, search_index_o=0, search_multi_o=0.
- Back-to-back requests every cycle are supported; there is no busy or stall state.

Test Plan:
1. Reset; write idx1=0x1, idx3=0x3, idx5=0x5, idx7=0x7 on consecutive cycles → occupancy_o steps 1,2,3,4. A read of idx3 returns read_valid_o=1, 0x00000003 one cycle later. A read of idx4 returns read_valid_o=0, value 0.
2. Same cycle: read idx5, write idx5=0x9, search key 0x5 with mask all-ones → read returns 0x5, search returns valid=1, idx5. The following cycle, a search for 0x5 misses and a search for 0x9 hits idx5.
3. Write 0xAB00 to idx2 and 0xAB11 to idx9; search key 0xAB00 with mask 0xFF00 → search_valid_o=1, search_index_o=2, search_multi_o=1. With mask 0xFFFF → index 2, multi=0.
4. Invalidate idx2 → occupancy decrements. Repeat invalidate idx2 → no change. Read idx2 → valid=0. Same-cycle write+invalidate on idx2 → entry valid with the new data, occupancy +1.
5. Fill all 32 entries → full_o=1, occupancy_o=32. An overwrite keeps 32. One invalidate → 31, full_o=0. A search with mask 0 → index 0, multi=1.
6. Assert reset_i=0 during a cycle that also carries write, invalidate and search → the next cycle shows all outputs 0 and occupancy 0. A read of any previously written entry returns valid=0.
